// File: rtl/issue_buffer_pkg.sv
// Shared widths, decode_out field offsets and next-pc codes for the issue buffer.
package issue_buffer_pkg;

    localparam int unsigned DECODEOUT_W = 32;
    localparam int unsigned REG_W       = 5;
    localparam int unsigned NPCOP_W     = 3;

    localparam int unsigned DEC_RS    = 0;
    localparam int unsigned DEC_RT    = 5;
    localparam int unsigned DEC_RD    = 10;
    localparam int unsigned DEC_RSV   = 15;
    localparam int unsigned DEC_RTV   = 16;
    localparam int unsigned DEC_RFWE  = 17;
    localparam int unsigned DEC_NPCOP = 18;

    localparam logic [NPCOP_W-1:0] NPC_PLUS4  = 3'd0;
    localparam logic [NPCOP_W-1:0] NPC_BRANCH = 3'd1;

    typedef struct packed {
        logic [NPCOP_W-1:0] npcop;
        logic               rfwe;
        logic [REG_W-1:0]   rd;
    } head_haz_t;

    typedef struct packed {
        logic             rfwe;
        logic             rs_v;
        logic             rt_v;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
    } next_haz_t;

endpackage

// File: rtl/issue_buffer_pair_check.sv
// Decides whether the two oldest queued instructions must issue in separate cycles.
module issue_pair_check
    import issue_buffer_pkg::*;
(
    input  head_haz_t head_haz,
    input  next_haz_t h1_haz,
    output logic      split
);

    logic raw;
    logic waw;
    logic ctl;

    always_comb begin
        raw   = head_haz.rfwe && (head_haz.rd != '0) &&
                ((h1_haz.rs_v && (h1_haz.rs == head_haz.rd)) ||
                 (h1_haz.rt_v && (h1_haz.rt == head_haz.rd)));
        waw   = head_haz.rfwe && h1_haz.rfwe && (head_haz.rd != '0) &&
                (h1_haz.rd == head_haz.rd);
        ctl   = (head_haz.npcop != NPC_PLUS4);
        split = raw || waw || ctl;
    end

endmodule

// File: rtl/issue_buffer.sv
// Circular queue of decoded instructions feeding two execute units with
// registered, order-tagged issue slots; splits hazardous pairs and flushes on redirect.
module issue_buffer
    import issue_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PC_W  = 32,
    parameter int unsigned DEC_W = DECODEOUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       enq_valid,
    output logic             enq_ready,
    input  logic [PC_W-1:0]  enq_pc0,
    input  logic [PC_W-1:0]  enq_pc1,
    input  logic [PC_W-1:0]  enq_npc0,
    input  logic [PC_W-1:0]  enq_npc1,
    input  logic [DEC_W-1:0] enq_dec0,
    input  logic [DEC_W-1:0] enq_dec1,
    input  logic             stop,
    input  logic             flush,
    output logic             iss_valid0,
    output logic             iss_valid1,
    output logic             iss_num0,
    output logic             iss_num1,
    output logic [PC_W-1:0]  iss_pc0,
    output logic [PC_W-1:0]  iss_pc1,
    output logic [PC_W-1:0]  iss_npc0,
    output logic [PC_W-1:0]  iss_npc1,
    output logic [DEC_W-1:0] iss_dec0,
    output logic [DEC_W-1:0] iss_dec1
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  pc_mem  [DEPTH];
    logic [PC_W-1:0]  npc_mem [DEPTH];
    logic [DEC_W-1:0] dec_mem [DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, h1_idx, tail_p1;
    logic [CNT_W-1:0] count_q, count_d;
    logic             seq_q, seq_d;
    logic             iss_valid0_q, iss_valid0_d, iss_valid1_q, iss_valid1_d;
    logic             iss_num0_q, iss_num0_d, iss_num1_q, iss_num1_d;
    logic [PC_W-1:0]  iss_pc0_q, iss_pc0_d, iss_pc1_q, iss_pc1_d;
    logic [PC_W-1:0]  iss_npc0_q, iss_npc0_d, iss_npc1_q, iss_npc1_d;
    logic [DEC_W-1:0] iss_dec0_q, iss_dec0_d, iss_dec1_q, iss_dec1_d;

    logic [DEC_W-1:0] h0_dec, h1_dec;
    head_haz_t        head_haz;
    next_haz_t        h1_haz;
    logic             split;
    logic [1:0]       enq_n, issue_n;

    assign h1_idx    = head_q + PTR_W'(1);
    assign tail_p1   = tail_q + PTR_W'(1);
    assign h0_dec    = dec_mem[head_q];
    assign h1_dec    = dec_mem[h1_idx];
    assign enq_ready = (count_q <= CNT_W'(DEPTH - 2));

    always_comb begin
        head_haz.npcop = h0_dec[DEC_NPCOP +: NPCOP_W];
        head_haz.rfwe  = h0_dec[DEC_RFWE];
        head_haz.rd    = h0_dec[DEC_RD +: REG_W];
        h1_haz.rfwe    = h1_dec[DEC_RFWE];
        h1_haz.rs_v    = h1_dec[DEC_RSV];
        h1_haz.rt_v    = h1_dec[DEC_RTV];
        h1_haz.rs      = h1_dec[DEC_RS +: REG_W];
        h1_haz.rt      = h1_dec[DEC_RT +: REG_W];
        h1_haz.rd      = h1_dec[DEC_RD +: REG_W];
    end

    issue_pair_check u_pair_check (
        .head_haz (head_haz),
        .h1_haz   (h1_haz),
        .split    (split)
    );

    always_comb begin
        enq_n        = 2'd0;
        issue_n      = 2'd0;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        seq_d        = seq_q;
        iss_valid0_d = iss_valid0_q;
        iss_valid1_d = iss_valid1_q;
        iss_num0_d   = iss_num0_q;
        iss_num1_d   = iss_num1_q;
        iss_pc0_d    = iss_pc0_q;
        iss_pc1_d    = iss_pc1_q;
        iss_npc0_d   = iss_npc0_q;
        iss_npc1_d   = iss_npc1_q;
        iss_dec0_d   = iss_dec0_q;
        iss_dec1_d   = iss_dec1_q;

        if (flush) begin
            // Redirect: discard everything queued or in flight, including this cycle's enqueue.
            head_d       = tail_q;
            count_d      = '0;
            seq_d        = 1'b0;
            iss_valid0_d = 1'b0;
            iss_valid1_d = 1'b0;
        end else begin
            if (enq_ready && enq_valid[0]) begin
                enq_n = enq_valid[1] ? 2'd2 : 2'd1;
            end
            if (!stop && (count_q != '0)) begin
                issue_n = ((count_q == CNT_W'(1)) || split) ? 2'd1 : 2'd2;
            end
            if (!stop) begin
                iss_valid0_d = (issue_n != 2'd0);
                iss_valid1_d = (issue_n == 2'd2);
                if (issue_n != 2'd0) begin
                    iss_num0_d = seq_q;
                    iss_pc0_d  = pc_mem[head_q];
                    iss_npc0_d = npc_mem[head_q];
                    iss_dec0_d = h0_dec;
                end
                if (issue_n == 2'd2) begin
                    iss_num1_d = ~seq_q;
                    iss_pc1_d  = pc_mem[h1_idx];
                    iss_npc1_d = npc_mem[h1_idx];
                    iss_dec1_d = h1_dec;
                end
            end
            head_d  = head_q + PTR_W'(issue_n);
            tail_d  = tail_q + PTR_W'(enq_n);
            count_d = count_q + CNT_W'(enq_n) - CNT_W'(issue_n);
            seq_d   = seq_q ^ (issue_n == 2'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (enq_n != 2'd0) begin
            pc_mem[tail_q]  <= enq_pc0;
            npc_mem[tail_q] <= enq_npc0;
            dec_mem[tail_q] <= enq_dec0;
        end
        if (enq_n == 2'd2) begin
            pc_mem[tail_p1]  <= enq_pc1;
            npc_mem[tail_p1] <= enq_npc1;
            dec_mem[tail_p1] <= enq_dec1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            seq_q        <= 1'b0;
            iss_valid0_q <= 1'b0;
            iss_valid1_q <= 1'b0;
            iss_num0_q   <= 1'b0;
            iss_num1_q   <= 1'b0;
            iss_pc0_q    <= '0;
            iss_pc1_q    <= '0;
            iss_npc0_q   <= '0;
            iss_npc1_q   <= '0;
            iss_dec0_q   <= '0;
            iss_dec1_q   <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            seq_q        <= seq_d;
            iss_valid0_q <= iss_valid0_d;
            iss_valid1_q <= iss_valid1_d;
            iss_num0_q   <= iss_num0_d;
            iss_num1_q   <= iss_num1_d;
            iss_pc0_q    <= iss_pc0_d;
            iss_pc1_q    <= iss_pc1_d;
            iss_npc0_q   <= iss_npc0_d;
            iss_npc1_q   <= iss_npc1_d;
            iss_dec0_q   <= iss_dec0_d;
            iss_dec1_q   <= iss_dec1_d;
        end
    end

    assign iss_valid0 = iss_valid0_q;
    assign iss_valid1 = iss_valid1_q;
    assign iss_num0   = iss_num0_q;
    assign iss_num1   = iss_num1_q;
    assign iss_pc0    = iss_pc0_q;
    assign iss_pc1    = iss_pc1_q;
    assign iss_npc0   = iss_npc0_q;
    assign iss_npc1   = iss_npc1_q;
    assign iss_dec0   = iss_dec0_q;
    assign iss_dec1   = iss_dec1_q;

endmodule

// File: tb/tb_issue_buffer.sv
// Directed bench for issue_buffer: reset, pairing, hazard splits, full queue and flush.
module tb_issue_buffer;
    import issue_buffer_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  enq_valid;
    logic        enq_ready;
    logic [31:0] enq_pc0, enq_pc1, enq_npc0, enq_npc1, enq_dec0, enq_dec1;
    logic        stop, flush;
    logic        iss_valid0, iss_valid1, iss_num0, iss_num1;
    logic [31:0] iss_pc0, iss_pc1, iss_npc0, iss_npc1, iss_dec0, iss_dec1;

    int total = 0;
    int bad   = 0;

    issue_buffer #(.DEPTH(8), .PC_W(32), .DEC_W(32)) dut (
        .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_pc0(enq_pc0), .enq_pc1(enq_pc1), .enq_npc0(enq_npc0), .enq_npc1(enq_npc1),
        .enq_dec0(enq_dec0), .enq_dec1(enq_dec1), .stop(stop), .flush(flush),
        .iss_valid0(iss_valid0), .iss_valid1(iss_valid1), .iss_num0(iss_num0), .iss_num1(iss_num1),
        .iss_pc0(iss_pc0), .iss_pc1(iss_pc1), .iss_npc0(iss_npc0), .iss_npc1(iss_npc1),
        .iss_dec0(iss_dec0), .iss_dec1(iss_dec1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // decode_out layout: rs[4:0] rt[9:5] rd[14:10] rs_v[15] rt_v[16] rfwe[17] npcop[20:18]
    function automatic logic [31:0] mk_dec(input logic [4:0] rs, input logic rs_v,
                                           input logic [4:0] rt, input logic rt_v,
                                           input logic [4:0] rd, input logic rfwe,
                                           input logic [2:0] npcop);
        return {11'd0, npcop, rfwe, rt_v, rs_v, rd, rt, rs};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd);
        return mk_dec(5'd0, 1'b1, 5'd0, 1'b0, rd, 1'b1, NPC_PLUS4);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] d0,
                       input logic [31:0] p1, input logic [31:0] d1);
        enq_valid = v;
        enq_pc0   = p0;
        enq_npc0  = p0 + 32'd4;
        enq_dec0  = d0;
        enq_pc1   = p1;
        enq_npc1  = p1 + 32'd4;
        enq_dec1  = d1;
    endtask

    task automatic idle();
        enq_valid = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1; stop = 1'b0; flush = 1'b0;
        enq(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        step(); step();
        rst = 1'b0;
        step();
        total++; if ({iss_valid1, iss_valid0} !== 2'b00) begin bad++; $display("FAIL rst_init_valid got=%b exp=00", {iss_valid1, iss_valid0}); end
        total++; if (enq_ready !== 1'b1) begin bad++; $display("FAIL rst_init_ready got=%b exp=1", enq_ready); end
        enq(2'b11, 32'h100, addi(5'd1), 32'h104, addi(5'd2));
        step();
        enq(2'b11, 32'h108, addi(5'd3), 32'h10C, addi(5'd4));
        step();
        total++; if ({iss_valid1, iss_valid0} !== 2'b11) begin bad++; $display("FAIL rst_traffic_valid got=%b exp=11", {iss_valid1, iss_valid0}); end
        #3 rst = 1'b1;
        #1;
        total++; if ({iss_valid1, iss_valid0} !== 2'b00) begin bad++; $display("FAIL rst_async_valid got=%b exp=00", {iss_valid1, iss_valid0}); end
        total++; if (enq_ready !== 1'b1) begin bad++; $display("FAIL rst_async_ready got=%b exp=1", enq_ready); end
        idle();
        step();
        rst = 1'b0;
        step(); step();
        total++; if ({iss_valid1, iss_valid0} !== 2'b00) begin bad++; $display("FAIL rst_queue_empty got=%b exp=00", {iss_valid1, iss_valid0}); end
    endtask

    task automatic test_pair();
        enq(2'b11, 32'h0, addi(5'd1), 32'h4, addi(5'd2));
        step();
        idle();
        step();
        total++; if ({iss_valid1, iss_valid0} !== 2'b11) begin bad++; $display("FAIL pair_valid got=%b exp=11", {iss_valid1, iss_valid0}); end
        total++; if (iss_pc0 !== 32'h0) begin bad++; $display("FAIL pair_pc0 got=%h exp=00000000", iss_pc0); end
        total++; if (iss_pc1 !== 32'h4) begin bad++; $display("FAIL pair_pc1 got=%h exp=00000004", iss_pc1); end
        total++; if (iss_npc1 !== 32'h8) begin bad++; $display("FAIL pair_npc1 got=%h exp=00000008", iss_npc1); end
        total++; if (iss_dec1 !== addi(5'd2)) begin bad++; $display("FAIL pair_dec1 got=%h exp=%h", iss_dec1, addi(5'd2)); end
        total++; if ({iss_num1, iss_num0} !== 2'b10) begin bad++; $display("FAIL pair_num got=%b exp=10", {iss_num1, iss_num0}); end
        step();
        total++; if ({iss_valid1, iss_valid0} !== 2'b00) begin bad++; $display("FAIL pair_drained got=%b exp=00", {iss_valid1, iss_valid0}); end
    endtask

    task automatic test_raw();
        enq(2'b11, 32'h10, addi(5'd5), 32'h14,
            mk_dec(5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, NPC_PLUS4));
        step();
        idle();
        step();
        total++; if ({iss_valid1, iss_valid0} !== 2'b01) begin bad++; $display("FAIL raw_first_valid got=%b exp=01", {iss_valid1, iss_valid0}); end
        total++; if (iss_pc0 !== 32'h10) begin bad++; $display("FAIL raw_first_pc got=%h exp=00000010", iss_pc0); end
        total++; if (iss_num0 !== 1'b0) begin bad++; $display("FAIL raw_first_num got=%b exp=0", iss_num0); end
        total++; if (iss_pc1 !== 32'h4) begin bad++; $display("FAIL raw_slot1_hold got=%h exp=00000004", iss_pc1); end
        step();
        total++; if ({iss_valid1, iss_valid0} !== 2'b01) begin bad++; $display("FAIL raw_second_valid got=%b exp=01", {iss_valid1, iss_valid0}); end
        total++; if (iss_pc0 !== 32'h14) begin bad++; $display("FAIL raw_second_pc got=%h exp=00000014", iss_pc0); end
        total++; if (iss_num0 !== 1'b1) begin bad++; $display("FAIL raw_second_num got=%b exp=1", iss_num0); end
        step();
    endtask

    task automatic test_control();
        enq(2'b11, 32'h8, mk_dec(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, NPC_BRANCH),
            32'hC, addi(5'd3));
        step();
        idle();
        step();
        total++; if ({iss_valid1, iss_valid0} !== 2'b01) begin bad++; $display("FAIL ctl_branch_valid got=%b exp=01", {iss_valid1, iss_valid0}); end
        total++; if (iss_pc0 !== 32'h8) begin bad++; $display("FAIL ctl_branch_pc got=%h exp=00000008", iss_pc0); end
        step();
        total++; if ({iss_valid1, iss_valid0} !== 2'b01) begin bad++; $display("FAIL ctl_next_valid got=%b exp=01", {iss_valid1, iss_valid0}); end
        total++; if (iss_pc0 !== 32'hC) begin bad++; $display("FAIL ctl_next_pc got=%h exp=0000000c", iss_pc0); end
        step();
    endtask

    task automatic test_full();
        logic [31:0] exp_pc [7];
        for (int i = 0; i < 7; i++) exp_pc[i] = 32'h200 + 32'(4 * i);
        stop = 1'b1;
        enq(2'b01, exp_pc[0], addi(5'd8), 32'h0, 32'h0);
        step();
        total++; if (enq_ready !== 1'b1) begin bad++; $display("FAIL full_ready_c1 got=%b exp=1", enq_ready); end
        for (int i = 0; i < 3; i++) begin
            enq(2'b11, exp_pc[1 + 2 * i], addi(5'(9 + 2 * i)), exp_pc[2 + 2 * i], addi(5'(10 + 2 * i)));
            step();
        end
        total++; if (enq_ready !== 1'b0) begin bad++; $display("FAIL full_ready_c7 got=%b exp=0", enq_ready); end
        total++; if ({iss_valid1, iss_valid0} !== 2'b00) begin bad++; $display("FAIL full_stop_hold got=%b exp=00", {iss_valid1, iss_valid0}); end
        enq(2'b11, 32'h300, addi(5'd20), 32'h304, addi(5'd21));
        step();
        total++; if (enq_ready !== 1'b0) begin bad++; $display("FAIL full_drop_ready got=%b exp=0", enq_ready); end
        idle();
        stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if ({iss_valid1, iss_valid0} !== 2'b11) begin bad++; $display("FAIL full_drain_valid%0d got=%b exp=11", i, {iss_valid1, iss_valid0}); end
            total++; if (iss_pc0 !== exp_pc[2 * i]) begin bad++; $display("FAIL full_drain_pc0_%0d got=%h exp=%h", i, iss_pc0, exp_pc[2 * i]); end
            total++; if (iss_pc1 !== exp_pc[2 * i + 1]) begin bad++; $display("FAIL full_drain_pc1_%0d got=%h exp=%h", i, iss_pc1, exp_pc[2 * i + 1]); end
        end
        step();
        total++; if ({iss_valid1, iss_valid0} !== 2'b01) begin bad++; $display("FAIL full_last_valid got=%b exp=01", {iss_valid1, iss_valid0}); end
        total++; if (iss_pc0 !== exp_pc[6]) begin bad++; $display("FAIL full_last_pc got=%h exp=%h", iss_pc0, exp_pc[6]); end
        total++; if (iss_num0 !== 1'b0) begin bad++; $display("FAIL full_last_num got=%b exp=0", iss_num0); end
        step();
        total++; if ({iss_valid1, iss_valid0} !== 2'b00) begin bad++; $display("FAIL full_dropped_absent got=%b exp=00", {iss_valid1, iss_valid0}); end
        total++; if (enq_ready !== 1'b1) begin bad++; $display("FAIL full_empty_ready got=%b exp=1", enq_ready); end
    endtask

    task automatic test_flush();
        enq(2'b11, 32'h400, addi(5'd1), 32'h404, addi(5'd2));
        step();
        enq(2'b11, 32'h408, addi(5'd3), 32'h40C, addi(5'd4));
        step();
        total++; if ({iss_valid1, iss_valid0} !== 2'b11) begin bad++; $display("FAIL flush_pre_valid got=%b exp=11", {iss_valid1, iss_valid0}); end
        total++; if ({iss_num1, iss_num0} !== 2'b01) begin bad++; $display("FAIL flush_pre_num got=%b exp=01", {iss_num1, iss_num0}); end
        stop  = 1'b1;
        flush = 1'b1;
        enq(2'b11, 32'h500, addi(5'd5), 32'h504, addi(5'd6));
        step();
        total++; if ({iss_valid1, iss_valid0} !== 2'b00) begin bad++; $display("FAIL flush_valid got=%b exp=00", {iss_valid1, iss_valid0}); end
        total++; if (enq_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", enq_ready); end
        stop  = 1'b0;
        flush = 1'b0;
        idle();
        step(); step();
        total++; if ({iss_valid1, iss_valid0} !== 2'b00) begin bad++; $display("FAIL flush_empty got=%b exp=00", {iss_valid1, iss_valid0}); end
        enq(2'b11, 32'h600, addi(5'd7), 32'h604, addi(5'd8));
        step();
        idle();
        step();
        total++; if ({iss_valid1, iss_valid0} !== 2'b11) begin bad++; $display("FAIL flush_after_valid got=%b exp=11", {iss_valid1, iss_valid0}); end
        total++; if (iss_pc0 !== 32'h600) begin bad++; $display("FAIL flush_after_pc0 got=%h exp=00000600", iss_pc0); end
        total++; if ({iss_num1, iss_num0} !== 2'b10) begin bad++; $display("FAIL flush_after_num got=%b exp=10", {iss_num1, iss_num0}); end
        step();
    endtask

    initial begin
        test_reset();
        test_pair();
        test_raw();
        test_control();
        test_full();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
